// File: rtl/dmem_bridge_pkg.sv
// Shared types and defaults for the data-memory bridge.
package dmem_bridge_pkg;

    // Default RAM geometry: log2 word count and byte address of word 0.
    localparam int unsigned DATA_MEM_DEPTH = 10;
    localparam logic [31:0] DATA_MEM_START = 32'h8000_0000;

    // Busy-phase countdown width; LATENCY is limited to 1..15.
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // True when a physical byte offset lies beyond the last RAM word.
    // Compared at 33 bits so DEPTH=30 still yields a valid limit.
    function automatic logic out_of_range(input logic [31:0] paddr,
                                          input int unsigned depth);
        logic [32:0] limit;
        limit = 33'd4 << depth;
        return ({1'b0, paddr} >= limit);
    endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// Request/response channel between the CPU load/store port and the bridge.
interface dmem_bridge_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [STRB_W-1:0]     req_wstrb;
    logic [31:0]           req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    // CPU side: issues requests, consumes responses.
    modport master (
        output req_valid, req_we, req_wstrb, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    // Bridge side.
    modport slave (
        input  req_valid, req_we, req_wstrb, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_bridge_strb_merge.sv
// Byte-lane merge: lanes with a set strobe take the new byte, others keep the old one.
module strb_merge #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   old_word,
    input  logic [DATA_WIDTH-1:0]   new_word,
    input  logic [DATA_WIDTH/8-1:0] strb,
    output logic [DATA_WIDTH-1:0]   merged
);

    // Per-lane select between old and new byte.
    always_comb begin
        merged = old_word;
        for (int unsigned i = 0; i < DATA_WIDTH / 8; i++) begin
            if (strb[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_bridge.sv
// Data-memory front end: valid/ready request channel, fixed-latency access to an
// async-read RAM, read-modify-write byte stores, error reporting and the
// one-cycle dmem-write commit record.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = DATA_MEM_DEPTH,
    parameter logic [31:0] BASE_ADDR  = DATA_MEM_START,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_bridge_if.slave          bus,
    output logic [DEPTH-1:0]      ram_a,
    output logic [DATA_WIDTH-1:0] ram_d,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_spo,
    output logic                  cmt_we,
    output logic [31:0]           cmt_wa,
    output logic [DATA_WIDTH-1:0] cmt_wd
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_bridge: LATENCY must be in 1..15");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("dmem_bridge: DATA_WIDTH must be a multiple of 8");
    end

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;

    // Request register, loaded on accept and held through the access.
    logic                  rq_we;
    logic [STRB_W-1:0]     rq_wstrb;
    logic [31:0]           rq_addr;
    logic [DATA_WIDTH-1:0] rq_wdata;

    // Response register, loaded in the access cycle.
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic                  accept;
    logic                  access;
    logic [31:0]           paddr;
    logic                  addr_err;
    logic                  do_write;
    logic [DATA_WIDTH-1:0] merged;

    strb_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_merge (
        .old_word (ram_spo),
        .new_word (rq_wdata),
        .strb     (rq_wstrb),
        .merged   (merged)
    );

    // Decode of the latched request and handshake qualifiers.
    always_comb begin
        accept   = bus.req_valid && (state == ST_IDLE);
        access   = (state == ST_BUSY) && (cnt == '0);
        paddr    = rq_addr - BASE_ADDR;
        addr_err = (rq_addr[1:0] != 2'b00) || out_of_range(paddr, DEPTH);
        do_write = access && rq_we && !addr_err && (rq_wstrb != '0);
    end

    // State and busy-countdown register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and countdown logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_BUSY;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            ST_BUSY: begin
                if (cnt == '0) begin
                    state_nxt = ST_RESP;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Request capture on accept; response capture in the access cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rq_we     <= 1'b0;
            rq_wstrb  <= '0;
            rq_addr   <= '0;
            rq_wdata  <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                rq_we    <= bus.req_we;
                rq_wstrb <= bus.req_wstrb;
                rq_addr  <= bus.req_addr;
                rq_wdata <= bus.req_wdata;
            end
            if (access) begin
                rsp_rdata <= addr_err ? '0 : ram_spo;
                rsp_err   <= addr_err;
            end
        end
    end

    // Channel, RAM and commit outputs; writes are gated by rst so a reset
    // cycle never lands data even if it coincides with the access cycle.
    always_comb begin
        bus.req_ready  = (state == ST_IDLE);
        bus.resp_valid = (state == ST_RESP);
        bus.resp_rdata = rsp_rdata;
        bus.resp_err   = rsp_err;

        ram_a  = '0;
        ram_d  = '0;
        ram_we = 1'b0;
        cmt_we = 1'b0;
        cmt_wa = '0;
        cmt_wd = '0;

        if (access) begin
            ram_a = paddr[DEPTH+1:2];
            if (rq_we) begin
                ram_d = merged;
            end
        end
        if (do_write && rst) begin
            ram_we = 1'b1;
            cmt_we = 1'b1;
            cmt_wa = rq_addr;
            cmt_wd = merged;
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: three instances (LATENCY 2, 4, 1) share clk/rst,
// each backed by a small async-read RAM and checked against a
// transaction-level model every cycle.
module tb_dmem_bridge;

    localparam int unsigned DW   = 32;
    localparam int unsigned DP   = 4;
    localparam logic [31:0] BASE = 32'h1000_0000;

    function automatic int unsigned lat_of(input int u);
        if (u == 0) return 2;
        else if (u == 1) return 4;
        else return 1;
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Stimulus per unit
    logic        rv [3];
    logic        rwe [3];
    logic        rr [3];
    logic [3:0]  rs [3];
    logic [31:0] ra [3];
    logic [31:0] rd [3];

    // Observed outputs per unit
    logic        o_ready [3];
    logic        o_valid [3];
    logic        o_err [3];
    logic        o_ramwe [3];
    logic        o_cmtwe [3];
    logic [31:0] o_rdata [3];
    logic [31:0] o_ramd [3];
    logic [31:0] o_cmtwa [3];
    logic [31:0] o_cmtwd [3];
    logic [31:0] o_spo [3];
    logic [3:0]  o_rama [3];

    logic [31:0] ram [3][16];

    logic        pl_en = 1'b0;
    int          pl_u = 0;
    logic [3:0]  pl_i = '0;
    logic [31:0] pl_v = '0;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    bit chk_on = 1'b0;

    for (genvar g = 0; g < 3; g++) begin : g_u
        dmem_bridge_if #(.DATA_WIDTH(DW)) bus ();
        assign bus.req_valid  = rv[g];
        assign bus.req_we     = rwe[g];
        assign bus.req_wstrb  = rs[g];
        assign bus.req_addr   = ra[g];
        assign bus.req_wdata  = rd[g];
        assign bus.resp_ready = rr[g];
        assign o_ready[g]     = bus.req_ready;
        assign o_valid[g]     = bus.resp_valid;
        assign o_rdata[g]     = bus.resp_rdata;
        assign o_err[g]       = bus.resp_err;
        assign o_spo[g]       = ram[g][o_rama[g]];

        dmem_bridge #(
            .DATA_WIDTH (DW),
            .DEPTH      (DP),
            .BASE_ADDR  (BASE),
            .LATENCY    (lat_of(g))
        ) dut (
            .clk     (clk),
            .rst     (rst),
            .bus     (bus),
            .ram_a   (o_rama[g]),
            .ram_d   (o_ramd[g]),
            .ram_we  (o_ramwe[g]),
            .ram_spo (o_spo[g]),
            .cmt_we  (o_cmtwe[g]),
            .cmt_wa  (o_cmtwa[g]),
            .cmt_wd  (o_cmtwd[g])
        );
    end

    // RAM behaviour: write lands on the clock edge, read is asynchronous.
    always @(posedge clk) begin
        if (pl_en) ram[pl_u][pl_i] <= pl_v;
        for (int u = 0; u < 3; u++) begin
            if (o_ramwe[u]) ram[u][o_rama[u]] <= o_ramd[u];
        end
    end

    // ---------------- reference model ----------------
    bit          m_act [3];
    int unsigned m_t [3];
    logic        m_we [3];
    logic [3:0]  m_s [3];
    logic [31:0] m_a [3];
    logic [31:0] m_d [3];
    logic [31:0] m_rdata [3];
    logic        m_err [3];
    logic [31:0] mram [3][16];

    function automatic logic [31:0] merge_f(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~mask) | (n & mask);
    endfunction

    function automatic bit bad_f(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a - BASE) >= 32'd64);
    endfunction

    function automatic logic [3:0] idx_f(input logic [31:0] a);
        return 4'((a - BASE) >> 2);
    endfunction

    function automatic bit wok_f(input int u);
        return m_we[u] && !bad_f(m_a[u]) && (m_s[u] != 4'h0);
    endfunction

    // Timeline model: an accepted request occupies LATENCY cycles, the RAM is
    // touched on the last of them, then the response waits for resp_ready.
    always @(posedge clk) begin
        cyc++;
        if (pl_en) mram[pl_u][pl_i] = pl_v;
        for (int u = 0; u < 3; u++) begin
            if (!rst) begin
                m_act[u] = 1'b0;
            end else if (!m_act[u]) begin
                if (rv[u]) begin
                    m_act[u] = 1'b1;
                    m_t[u]   = 0;
                    m_we[u]  = rwe[u];
                    m_s[u]   = rs[u];
                    m_a[u]   = ra[u];
                    m_d[u]   = rd[u];
                end
            end else if (m_t[u] < lat_of(u)) begin
                if (m_t[u] == lat_of(u) - 1) begin
                    m_err[u]   = bad_f(m_a[u]);
                    m_rdata[u] = m_err[u] ? 32'h0 : mram[u][idx_f(m_a[u])];
                    if (wok_f(u))
                        mram[u][idx_f(m_a[u])] = merge_f(mram[u][idx_f(m_a[u])], m_d[u], m_s[u]);
                end
                m_t[u]++;
            end else if (rr[u]) begin
                m_act[u] = 1'b0;
            end
        end
    end

    task automatic chk_b(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chk_w(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    int          cmt_cnt [3] = '{0, 0, 0};
    int          we_cnt [3]  = '{0, 0, 0};
    logic [31:0] last_wa [3];
    logic [31:0] last_wd [3];

    // Per-cycle compare of every unit against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int u = 0; u < 3; u++) begin
                bit          ev;
                bit          ew;
                logic [3:0]  ix;
                logic [31:0] mw;
                ev = m_act[u] && (m_t[u] >= lat_of(u));
                ew = m_act[u] && (m_t[u] == lat_of(u) - 1) && wok_f(u) && (rst == 1'b1);
                ix = idx_f(m_a[u]);
                mw = merge_f(mram[u][ix], m_d[u], m_s[u]);
                chk_b($sformatf("u%0d req_ready c%0d", u, cyc), o_ready[u], !m_act[u]);
                chk_b($sformatf("u%0d resp_valid c%0d", u, cyc), o_valid[u], ev);
                if (ev) begin
                    chk_w($sformatf("u%0d resp_rdata c%0d", u, cyc), o_rdata[u], m_rdata[u]);
                    chk_b($sformatf("u%0d resp_err c%0d", u, cyc), o_err[u], m_err[u]);
                end
                chk_b($sformatf("u%0d ram_we c%0d", u, cyc), o_ramwe[u], ew);
                chk_b($sformatf("u%0d cmt_we c%0d", u, cyc), o_cmtwe[u], ew);
                if (ew) begin
                    chk_w($sformatf("u%0d ram_a c%0d", u, cyc), {28'h0, o_rama[u]}, {28'h0, ix});
                    chk_w($sformatf("u%0d ram_d c%0d", u, cyc), o_ramd[u], mw);
                    chk_w($sformatf("u%0d cmt_wa c%0d", u, cyc), o_cmtwa[u], m_a[u]);
                    chk_w($sformatf("u%0d cmt_wd c%0d", u, cyc), o_cmtwd[u], mw);
                end
                if (o_cmtwe[u] === 1'b1) begin
                    cmt_cnt[u]++;
                    last_wa[u] = o_cmtwa[u];
                    last_wd[u] = o_cmtwd[u];
                end
                if (o_ramwe[u] === 1'b1) we_cnt[u]++;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int u, input int i, input logic [31:0] v);
        pl_u  = u;
        pl_i  = 4'(i);
        pl_v  = v;
        pl_en = 1'b1;
        step();
        pl_en = 1'b0;
    endtask

    task automatic issue(input int u, input logic w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] d, output int acc);
        rv[u] = 1'b1; rwe[u] = w; rs[u] = s; ra[u] = a; rd[u] = d;
        acc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_ready[u]) begin
                step();
                acc = cyc;
                break;
            end
        end
        rv[u] = 1'b0;
        chk_b($sformatf("u%0d accept_in_time", u), acc >= 0, 1'b1);
    endtask

    task automatic wait_valid(input int u, output int vc, output logic [31:0] dat, output logic e);
        vc = -1; dat = '0; e = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_valid[u]) begin
                vc = cyc; dat = o_rdata[u]; e = o_err[u];
                break;
            end
        end
        step();
        chk_b($sformatf("u%0d resp_in_time", u), vc >= 0, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          acc;
        int          vc;
        logic [31:0] dat;
        logic        e;
        int          c0;
        int          w0;
        int          accs [4];
        int          vcs [4];
        bit          found;

        for (int u = 0; u < 3; u++) begin
            rv[u] = 1'b0; rwe[u] = 1'b0; rr[u] = 1'b1; rs[u] = '0; ra[u] = '0; rd[u] = '0;
        end
        for (int u = 0; u < 3; u++)
            for (int i = 0; i < 16; i++)
                preload(u, i, 32'hC000_0000 | 32'(u << 8) | 32'(i));
        rst = 1'b1;
        chk_on = 1'b1;

        // Reset state
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            chk_b($sformatf("u%0d reset ready", u), o_ready[u], 1'b1);
            chk_b($sformatf("u%0d reset valid", u), o_valid[u], 1'b0);
            chk_w($sformatf("u%0d reset rdata", u), o_rdata[u], 32'h0);
            chk_b($sformatf("u%0d reset err", u), o_err[u], 1'b0);
        end
        step();

        // Load, LATENCY=2
        preload(0, 5, 32'hDEAD_BEEF);
        w0 = we_cnt[0];
        issue(0, 1'b0, 4'h0, BASE + 32'h14, 32'h0, acc);
        wait_valid(0, vc, dat, e);
        chk_w("load latency", 32'(vc - acc + 1), 32'd3);
        chk_w("load rdata", dat, 32'hDEAD_BEEF);
        chk_b("load err", e, 1'b0);
        chk_w("load no ram_we", 32'(we_cnt[0] - w0), 32'd0);

        // Byte store
        preload(0, 0, 32'h1122_3344);
        c0 = cmt_cnt[0];
        issue(0, 1'b1, 4'b0010, BASE, 32'h0000_AA00, acc);
        wait_valid(0, vc, dat, e);
        chk_w("bstore rdata", dat, 32'h1122_3344);
        chk_b("bstore err", e, 1'b0);
        chk_w("bstore ram", ram[0][0], 32'h1122_AA44);
        chk_w("bstore cmt count", 32'(cmt_cnt[0] - c0), 32'd1);
        chk_w("bstore cmt_wa", last_wa[0], BASE);
        chk_w("bstore cmt_wd", last_wd[0], 32'h1122_AA44);

        // Half-word store
        preload(0, 2, 32'h1234_5678);
        issue(0, 1'b1, 4'b1100, BASE + 32'h8, 32'hCAFE_0000, acc);
        wait_valid(0, vc, dat, e);
        chk_w("hstore rdata", dat, 32'h1234_5678);
        chk_w("hstore ram", ram[0][2], 32'hCAFE_5678);

        // Errors: misaligned store, out-of-range load
        c0 = cmt_cnt[0];
        w0 = we_cnt[0];
        issue(0, 1'b1, 4'hF, BASE + 32'h2, 32'h5555_5555, acc);
        wait_valid(0, vc, dat, e);
        chk_b("misalign err", e, 1'b1);
        chk_w("misalign rdata", dat, 32'h0);
        chk_w("misalign latency", 32'(vc - acc + 1), 32'd3);
        issue(0, 1'b0, 4'h0, BASE + 32'd64, 32'h0, acc);
        wait_valid(0, vc, dat, e);
        chk_b("range err", e, 1'b1);
        chk_w("range rdata", dat, 32'h0);
        chk_w("err ram unchanged", ram[0][0], 32'h1122_AA44);
        chk_w("err no cmt", 32'(cmt_cnt[0] - c0), 32'd0);
        chk_w("err no ram_we", 32'(we_cnt[0] - w0), 32'd0);

        // Store with empty strobe
        preload(0, 3, 32'h3333_3333);
        c0 = cmt_cnt[0];
        issue(0, 1'b1, 4'h0, BASE + 32'hC, 32'hFFFF_FFFF, acc);
        wait_valid(0, vc, dat, e);
        chk_w("nostrb rdata", dat, 32'h3333_3333);
        chk_b("nostrb err", e, 1'b0);
        chk_w("nostrb no cmt", 32'(cmt_cnt[0] - c0), 32'd0);
        chk_w("nostrb ram", ram[0][3], 32'h3333_3333);

        // Backpressure: 5 cycles of resp_ready=0
        rr[0] = 1'b0;
        issue(0, 1'b0, 4'h0, BASE + 32'h14, 32'h0, acc);
        wait_valid(0, vc, dat, e);
        chk_w("bp rdata", dat, 32'hDEAD_BEEF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk_b("bp valid held", o_valid[0], 1'b1);
            chk_w("bp rdata held", o_rdata[0], 32'hDEAD_BEEF);
            chk_b("bp err held", o_err[0], 1'b0);
            chk_b("bp ready low", o_ready[0], 1'b0);
            step();
        end
        rr[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_b("bp idle after handshake", o_ready[0], 1'b1);
        chk_b("bp valid dropped", o_valid[0], 1'b0);
        step();

        // Reset in the middle of a LATENCY=4 store
        preload(1, 7, 32'h7777_0000);
        issue(1, 1'b0, 4'h0, BASE + 32'h1C, 32'h0, acc);
        wait_valid(1, vc, dat, e);
        chk_w("u1 load rdata", dat, 32'h7777_0000);
        chk_w("u1 load latency", 32'(vc - acc + 1), 32'd5);
        c0 = cmt_cnt[1];
        w0 = we_cnt[1];
        issue(1, 1'b1, 4'hF, BASE + 32'h1C, 32'h1212_1212, acc);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        chk_b("rstmid ready", o_ready[1], 1'b1);
        chk_b("rstmid valid", o_valid[1], 1'b0);
        chk_w("rstmid rdata", o_rdata[1], 32'h0);
        chk_b("rstmid err", o_err[1], 1'b0);
        chk_b("rstmid ram_we", o_ramwe[1], 1'b0);
        chk_b("rstmid cmt_we", o_cmtwe[1], 1'b0);
        step();
        repeat (6) step();
        chk_w("rstmid ram unchanged", ram[1][7], 32'h7777_0000);
        chk_w("rstmid no cmt", 32'(cmt_cnt[1] - c0), 32'd0);
        chk_w("rstmid no ram_we", 32'(we_cnt[1] - w0), 32'd0);

        // Back-to-back loads, LATENCY=1, req_valid held high
        for (int i = 0; i < 4; i++) preload(2, 8 + i, 32'hB0B0_0000 + 32'(i));
        rr[2] = 1'b1; rv[2] = 1'b1; rwe[2] = 1'b0; rs[2] = '0; ra[2] = BASE + 32'h20;
        for (int k = 0; k < 4; k++) begin
            found = 1'b0;
            for (int j = 0; j < 20; j++) begin
                @(negedge clk);
                if (o_ready[2]) begin found = 1'b1; break; end
            end
            step();
            accs[k] = cyc;
            ra[2] = BASE + 32'h20 + 32'(4 * (k + 1));
            if (k == 3) rv[2] = 1'b0;
            chk_b($sformatf("b2b accept %0d", k), found, 1'b1);
            vcs[k] = -1;
            dat = '0;
            for (int j = 0; j < 20; j++) begin
                @(negedge clk);
                if (o_valid[2]) begin vcs[k] = cyc; dat = o_rdata[2]; break; end
            end
            step();
            chk_w($sformatf("b2b latency %0d", k), 32'(vcs[k] - accs[k] + 1), 32'd2);
            chk_w($sformatf("b2b rdata %0d", k), dat, 32'hB0B0_0000 + 32'(k));
            if (k > 0) chk_w($sformatf("b2b spacing %0d", k), 32'(accs[k] - accs[k-1]), 32'd3);
        end
        rv[2] = 1'b0;
        repeat (3) step();

        // Final RAM image against the model
        for (int u = 0; u < 3; u++)
            for (int i = 0; i < 16; i++)
                chk_w($sformatf("ram u%0d[%0d]", u, i), ram[u][i], mram[u][i]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
